// File: rtl/tx_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tx_frame_decoder
// Description : Receive-side decoder for the 10-bit checksum frame
//               {~popcount(payload)[2:0], payload[6:0]}. Checks each accepted
//               frame, buffers payload plus error flag in a small FIFO and
//               keeps a saturating count of bad frames.
//               Optional macro TX_FRAME_DECODER_DROP_BAD_EN: bad frames are
//               counted but not stored, and out_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_frame_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [6:0]       out_data,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

`ifdef TX_FRAME_DECODER_DROP_BAD_EN
  // Only good frames are stored, so no per-entry flag is needed
  localparam int ENTRY_W = 7;
`else
  // Each entry carries {bad, payload}
  localparam int ENTRY_W = 8;
`endif

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic [CNT_W-1:0]   r_err_count;

  logic [2:0]         w_pop_cnt;
  logic               w_bad;
  logic               w_accept;
  logic               w_write;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_entry;

  // Popcount of the payload bits; 7 bits never overflow a 3-bit sum
  always_comb begin
    w_pop_cnt = 3'd0;
    for (int i = 0; i < 7; i++) begin
      w_pop_cnt = w_pop_cnt + {2'b00, in_data[i]};
    end
  end

  assign w_bad     = (in_data[9:7] != ~w_pop_cnt);
  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign err_count = r_err_count;

`ifdef TX_FRAME_DECODER_DROP_BAD_EN
  assign w_write  = w_accept && !w_bad;
  assign w_entry  = in_data[6:0];
  assign out_data = out_valid ? r_mem[r_rd_ptr] : 7'd0;
  assign out_err  = 1'b0;
`else
  assign w_write  = w_accept;
  assign w_entry  = {w_bad, in_data[6:0]};
  assign out_data = out_valid ? r_mem[r_rd_ptr][6:0] : 7'd0;
  assign out_err  = out_valid ? r_mem[r_rd_ptr][7] : 1'b0;
`endif

  // FIFO storage; contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; occupancy is
  // kept separately so full and empty are distinguishable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating bad-frame counter; a clear coinciding with a bad accept
  // leaves that frame counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (clr_count) begin
      r_err_count <= (w_accept && w_bad) ? CNT_W'(1) : '0;
    end else if (w_accept && w_bad && (r_err_count != '1)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_frame_decoder
// Description : Directed plus randomized bench for tx_frame_decoder against a
//               queue-based reference model (DEPTH = 4, CNT_W = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_frame_decoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [9:0]       in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [6:0]       out_data;
  logic             out_err;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             clr_count = 1'b0;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: queue of {err, payload} and bad-frame count
  logic [7:0] mq[$];
  int         mcnt = 0;

  tx_frame_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clr_count (clr_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] good_check(input logic [6:0] p);
    return 3'(7 - $countones(p));
  endfunction

  function automatic logic [9:0] make_frame(input logic [6:0] p, input logic good);
    logic [2:0] c;
    c = good_check(p);
    if (!good) c = c ^ 3'($urandom_range(1, 7));
    return {c, p};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] head;
    head = (mq.size() != 0) ? mq[0] : 8'd0;
    check({tag, ".in_ready"},  32'(in_ready),  32'(mq.size() != DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    check({tag, ".out_data"},  32'(out_data),  32'(head[6:0]));
    check({tag, ".out_err"},   32'(out_err),   32'(head[7]));
    check({tag, ".err_count"}, 32'(err_count), 32'(mcnt));
  endtask

  // One clock cycle: check state at the falling edge, drive inputs, then
  // advance the model on the rising edge
  task automatic cycle(input string tag, input logic [9:0] d, input logic v,
                       input logic r, input logic c);
    logic acc, pop, bad;
    @(negedge clk);
    check_outputs(tag);
    in_data = d; in_valid = v; out_ready = r; clr_count = c;
    @(posedge clk);
    acc = v && (mq.size() < DEPTH);
    pop = r && (mq.size() > 0);
    bad = (d[9:7] != good_check(d[6:0]));
    if (pop) void'(mq.pop_front());
`ifdef TX_FRAME_DECODER_DROP_BAD_EN
    if (acc && !bad) mq.push_back({1'b0, d[6:0]});
`else
    if (acc) mq.push_back({bad, d[6:0]});
`endif
    if (c) mcnt = (acc && bad) ? 1 : 0;
    else if (acc && bad && mcnt < CNT_MAX) mcnt++;
  endtask

  task automatic idle(input string tag, input logic r, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 10'd0, 1'b0, r, 1'b0);
  endtask

  initial begin
    logic [6:0] p;
    logic       g;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_outputs("reset");

    // Good frame, bad frame and extreme payloads
    cycle("good", 10'b011_1010101, 1'b1, 1'b1, 1'b0);
    cycle("bad",  10'b000_1010101, 1'b1, 1'b1, 1'b0);
    cycle("zero", 10'b111_0000000, 1'b1, 1'b1, 1'b0);
    cycle("ones", 10'b000_1111111, 1'b1, 1'b1, 1'b0);
    idle("drain0", 1'b1, 3);

    // Fill to full with 5 distinct good frames, then release
    for (int i = 0; i < 5; i++) begin
      p = 7'(8'h11 * (i + 1));
      cycle("fill", make_frame(p, 1'b1), 1'b1, 1'b0, 1'b0);
    end
    check_outputs("full");
    cycle("release", make_frame(7'h55, 1'b1), 1'b1, 1'b1, 1'b0);
    cycle("release", make_frame(7'h55, 1'b1), 1'b1, 1'b1, 1'b0);
    idle("drain1", 1'b1, DEPTH + 1);

    // Simultaneous push and pop at occupancy 2 across pointer wrap
    cycle("pre2", make_frame(7'h01, 1'b1), 1'b1, 1'b0, 1'b0);
    cycle("pre2", make_frame(7'h02, 1'b1), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle("pushpop", make_frame(7'(i + 3), 1'b1), 1'b1, 1'b1, 1'b0);
    end
    idle("drain2", 1'b1, DEPTH + 1);

    // Counter saturation and clear coinciding with a bad accept
    for (int i = 0; i < 5; i++) begin
      cycle("sat", make_frame(7'($urandom), 1'b0), 1'b1, 1'b1, 1'b0);
    end
    cycle("clrbad", make_frame(7'h2A, 1'b0), 1'b1, 1'b1, 1'b1);
    cycle("clronly", 10'd0, 1'b0, 1'b1, 1'b1);
    idle("drain3", 1'b1, DEPTH + 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      p = 7'($urandom);
      g = ($urandom_range(0, 3) != 0);
      cycle("rand", make_frame(p, g), 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
    end
    idle("drain4", 1'b1, DEPTH + 1);

    // Reset mid-operation with 3 entries queued and err_count = 2
    cycle("mr", make_frame(7'h10, 1'b0), 1'b1, 1'b0, 1'b1);
    cycle("mr", make_frame(7'h20, 1'b0), 1'b1, 1'b0, 1'b0);
    cycle("mr", make_frame(7'h30, 1'b1), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_outputs("pre_rst");
    in_valid = 1'b0; out_ready = 1'b0; clr_count = 1'b0;
    rst = 1'b1;
    #1;
    mq.delete();
    mcnt = 0;
    check_outputs("mid_rst");
    #1 rst = 1'b0;
    cycle("post_rst", 10'b011_1010101, 1'b1, 1'b1, 1'b0);
    idle("post_rst", 1'b1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute bound so the run always terminates
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/tx_frame_decoder.md
# tx_frame_decoder

Receive-side decoder for the 10-bit checksum frame produced by the transmit encoder.
- Frame format: bits [9:7] = bitwise inverse of the popcount of bits [6:0]; bits [6:0] = payload.
- Accepts frames over a valid/ready handshake, checks the checksum and buffers decoded payloads in a small FIFO with a per-entry error flag.
- Keeps a saturating count of bad frames for status readout.
- Sits between the link/receive front end and the consumer of 7-bit data.

## Interface

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- CNT_W, 16, width of the error counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  10  received frame {check[2:0], payload[6:0]}
- in_valid  input  1  in_data is valid
- in_ready  output  1  decoder can accept a frame (FIFO not full)
- out_data  output  7  payload at FIFO head
- out_err  output  1  checksum mismatch flag for the head entry
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer takes the head entry
- clr_count  input  1  synchronous clear of err_count
- err_count  output  CNT_W  saturating count of bad frames

## Operation

- **Accept:** a frame is accepted when in_valid && in_ready at a rising edge.
- **Check:** computed combinationally on in_data.
  - 3-bit unsigned popcount of in_data[6:0]; range 0..7, no overflow.
  - expected = ~popcount.
  - bad = (in_data[9:7] != expected).
- **Write:** {bad, in_data[6:0]} is written into the FIFO at the write pointer on the same edge as acceptance.
- **Pop:** occurs when out_valid && out_ready. The read pointer advances.
- **Output data:** out_data and out_err are the head entry. Both are driven 0 while out_valid = 0.
- **Pointers and occupancy:** write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is a separate counter of width log2(DEPTH)+1.
- **Handshake rules:**
  - in_ready = (occupancy != DEPTH).
  - out_valid = (occupancy != 0).
  - Both are derived from registered occupancy only, with no combinational path from out_ready to in_ready.
- **Simultaneous push and pop:**
  - When not full and not empty: occupancy unchanged, both pointers advance.
  - When full: no push is possible, because in_ready = 0 even if a pop occurs that cycle.
- **Error counter:**
  - Increments by 1 on each accepted bad frame and saturates at all-ones.
  - clr_count sets it to 0. If clr_count and an accepted bad frame occur in the same cycle, the result is 1.
- **Payload handling:** bad frames are stored and forwarded with out_err = 1 (default build).
- **Reset values:**
  - rst asserted at any time, including mid-stream, immediately clears pointers, occupancy and err_count.
  - Resulting outputs: in_ready = 1, out_valid = 0, out_data = 0, out_err = 0, err_count = 0.
  - FIFO contents are discarded.

## Timing

- Latency is 1 cycle: a frame accepted at edge N appears at the head with out_valid = 1 after edge N, provided the FIFO was empty.
- Throughput is 1 frame/cycle while neither full nor stalled.
- in_ready falls in the cycle after the edge that makes occupancy = DEPTH. It rises in the cycle after the first pop from full.
- err_count updates on the acceptance edge of a bad frame. This is the same edge as the FIFO write.
- rst is asynchronous assert. Deassertion is assumed synchronized upstream; the first accept is possible at the first clk edge with rst low.

## Configuration

- Macro: TX_FRAME_DECODER_DROP_BAD_EN.
- **Undefined (default):** every accepted frame is written to the FIFO; out_err reports checksum status.
- **Defined:**
  - Bad frames are still accepted (in_ready behaviour unchanged) and still counted in err_count, but are not written to the FIFO.
  - Occupancy does not change on a bad accept.
  - out_err is tied to 0.

## Test plan

- **Good frame:** in_data = 10'b011_1010101 (popcount 4), out_ready = 1 -> one cycle later out_valid = 1, out_data = 7'b1010101, out_err = 0, err_count = 0.
- **Bad frame and extreme payloads:**
  - in_data = 10'b000_1010101 -> out_err = 1, err_count = 1; with DROP_BAD_EN defined, out_valid stays 0 and err_count = 1.
  - 10'b111_0000000 and 10'b000_1111111 -> both decode with out_err = 0.
- **Full and ordering:** DEPTH = 4, out_ready = 0, present 5 distinct good frames back-to-back -> 4 accepted, in_ready = 0 after the 4th. Raise out_ready -> the 4 payloads emerge in order, then the 5th is accepted.
- **Simultaneous push/pop:** occupancy = 2, push and pop in the same cycle -> occupancy stays 2, order is preserved across pointer wrap.
- **Counter saturation and clear:** CNT_W = 2, 5 bad frames -> err_count = 3. clr_count in the same cycle as a bad accept -> err_count = 1.
- **Reset mid-operation:** with 3 entries queued and err_count = 2, pulse rst between edges -> out_valid = 0, in_ready = 1, err_count = 0 immediately. The next frame decodes normally.
